// File: rtl/mdu_ctrl.sv
// Execute-stage multiply/divide controller: accepts MDU commands, times the
// multi-cycle latency with a down-counter and owns the architectural HI/LO pair.
//
// state  | meaning
// -------+-------------------------------------------------------------
// S_IDLE | no operation in flight; starts and MTHI/MTLO are accepted
// S_BUSY | result held in shadow regs, counter running down to commit
module mdu_ctrl #(
    parameter int unsigned MULT_CYCLES = 5,
    parameter int unsigned DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  E_MDUOp,
    input  logic [31:0] E_RS,
    input  logic [31:0] E_RT,
    input  logic        Req,
    output logic        E_Start,
    output logic        E_Busy,
    output logic [31:0] E_HI,
    output logic [31:0] E_LO
);

    localparam int unsigned MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int unsigned CNT_W      = $clog2(MAX_CYCLES + 1);

    localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES);
    localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    localparam logic [3:0] OP_MULT  = 4'd1;
    localparam logic [3:0] OP_MULTU = 4'd2;
    localparam logic [3:0] OP_DIV   = 4'd3;
    localparam logic [3:0] OP_DIVU  = 4'd4;
    localparam logic [3:0] OP_MTHI  = 4'd5;
    localparam logic [3:0] OP_MTLO  = 4'd6;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_BUSY = 1'b1
    } state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             busy_q, busy_d;
    logic [31:0]      hi_q, hi_d;
    logic [31:0]      lo_q, lo_d;
    logic [31:0]      shadow_hi_q, shadow_hi_d;
    logic [31:0]      shadow_lo_q, shadow_lo_d;

    logic        op_is_mul;
    logic        op_is_div;
    logic [63:0] prod_s;
    logic [63:0] prod_u;
    logic        div_zero;
    logic        rs_neg;
    logic        rt_neg;
    logic [31:0] rs_mag;
    logic [31:0] rt_mag;
    logic [31:0] q_mag;
    logic [31:0] r_mag;
    logic [31:0] q_u;
    logic [31:0] r_u;
    logic [31:0] q_s;
    logic [31:0] r_s;
    logic [31:0] res_hi;
    logic [31:0] res_lo;

    assign op_is_mul = (E_MDUOp == OP_MULT) || (E_MDUOp == OP_MULTU);
    assign op_is_div = (E_MDUOp == OP_DIV)  || (E_MDUOp == OP_DIVU);

    // Low 64 bits of the sign-extended product equal the signed 32x32 product.
    assign prod_u = {32'd0, E_RS} * {32'd0, E_RT};
    assign prod_s = {{32{E_RS[31]}}, E_RS} * {{32{E_RT[31]}}, E_RT};

    assign div_zero = (E_RT == 32'd0);

    // Signed divide on magnitudes; -2^31 has magnitude 2^31, which keeps the
    // 0x80000000 / -1 case well defined (quotient wraps back to 0x80000000).
    always_comb begin
        rs_neg = E_RS[31];
        rt_neg = E_RT[31];
        rs_mag = rs_neg ? (~E_RS + 32'd1) : E_RS;
        rt_mag = rt_neg ? (~E_RT + 32'd1) : E_RT;
        q_mag  = 32'd0;
        r_mag  = 32'd0;
        q_u    = 32'd0;
        r_u    = 32'd0;
        if (!div_zero) begin
            q_mag = rs_mag / rt_mag;
            r_mag = rs_mag % rt_mag;
            q_u   = E_RS / E_RT;
            r_u   = E_RS % E_RT;
        end
        q_s = (rs_neg ^ rt_neg) ? (~q_mag + 32'd1) : q_mag;
        r_s = rs_neg ? (~r_mag + 32'd1) : r_mag;
    end

    always_comb begin
        res_hi = hi_q;
        res_lo = lo_q;
        case (E_MDUOp)
            OP_MULT: begin
                res_hi = prod_s[63:32];
                res_lo = prod_s[31:0];
            end
            OP_MULTU: begin
                res_hi = prod_u[63:32];
                res_lo = prod_u[31:0];
            end
            OP_DIV: begin
                if (!div_zero) begin
                    res_hi = r_s;
                    res_lo = q_s;
                end
            end
            OP_DIVU: begin
                if (!div_zero) begin
                    res_hi = r_u;
                    res_lo = q_u;
                end
            end
            default: begin
                res_hi = hi_q;
                res_lo = lo_q;
            end
        endcase
    end

    assign E_Start = (state_q == S_IDLE) && !Req && (op_is_mul || op_is_div);
    assign E_Busy  = E_Start || busy_q;
    assign E_HI    = hi_q;
    assign E_LO    = lo_q;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        busy_d      = busy_q;
        hi_d        = hi_q;
        lo_d        = lo_q;
        shadow_hi_d = shadow_hi_q;
        shadow_lo_d = shadow_lo_q;
        case (state_q)
            S_IDLE: begin
                if (E_Start) begin
                    shadow_hi_d = res_hi;
                    shadow_lo_d = res_lo;
                    cnt_d       = op_is_mul ? MULT_LOAD : DIV_LOAD;
                    busy_d      = 1'b1;
                    state_d     = S_BUSY;
                end else if (!Req && (E_MDUOp == OP_MTHI)) begin
                    hi_d = E_RS;
                end else if (!Req && (E_MDUOp == OP_MTLO)) begin
                    lo_d = E_RS;
                end
            end
            S_BUSY: begin
                // Commands and Req are deliberately ignored while in flight.
                if (cnt_q == CNT_ONE) begin
                    hi_d    = shadow_hi_q;
                    lo_d    = shadow_lo_q;
                    cnt_d   = '0;
                    busy_d  = 1'b0;
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            default: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            busy_q      <= 1'b0;
            hi_q        <= 32'd0;
            lo_q        <= 32'd0;
            shadow_hi_q <= 32'd0;
            shadow_lo_q <= 32'd0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            busy_q      <= busy_d;
            hi_q        <= hi_d;
            lo_q        <= lo_d;
            shadow_hi_q <= shadow_hi_d;
            shadow_lo_q <= shadow_lo_d;
        end
    end

endmodule

// File: doc/mdu_ctrl.md
Name: mdu_ctrl

Overview:
- Execute-stage multiply/divide controller for the pipelined MIPS core.
- Accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO commands, sequences the multi-cycle latency with an internal counter, and owns the HI/LO registers.
- Drives the busy signal that the hazard unit uses to stall MFHI/MFLO and later MDU instructions.
- Honours the exception/interrupt request so no new MDU side effect commits for a flushed instruction.

Parameters:
MULT_CYCLES, 5, busy cycles for MULT/MULTU (>=1)
DIV_CYCLES, 10, busy cycles for DIV/DIVU (>=1)

Ports:
clk  input  1  system clock, rising edge
reset  input  1  synchronous, active-low reset
E_MDUOp  input  4  0 NOP, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MTHI, 6 MTLO; 7-15 reserved, treated as NOP
E_RS  input  32  operand A / MTHI/MTLO source
E_RT  input  32  operand B
Req  input  1  exception/interrupt flush of the E-stage instruction this cycle
E_Start  output  1  high when a MULT/MULTU/DIV/DIVU is accepted this cycle
E_Busy  output  1  stall request to the hazard unit
E_HI  output  32  architectural HI
E_LO  output  32  architectural LO

Behaviour:
- Reset (reset==0 at a clk edge): state IDLE, counter=0, HI=LO=0, shadow regs=0. Outputs after reset: E_Busy=0, E_HI=E_LO=0.
- Reset is honoured mid-operation: the pending result is discarded and HI/LO are cleared.
- FSM states:
  - IDLE: busy_reg=0.
  - BUSY: busy_reg=1, counter!=0.
- E_Start = (state==IDLE) & ~Req & (E_MDUOp in 1..4). Combinational.
- E_Busy = E_Start | busy_reg. The start cycle itself stalls dependents.
- Accepting a start at edge T:
  - Compute the full result combinationally from E_RS/E_RT and latch it into shadow HI/LO.
  - Load counter = MULT_CYCLES or DIV_CYCLES.
  - Go to BUSY.
- In BUSY:
  - The counter decrements each edge.
  - At the edge where counter==1, shadow is copied to HI/LO, counter becomes 0, and the FSM returns to IDLE.
  - busy_reg is therefore high for exactly N cycles after the start cycle.
  - The new HI/LO is visible in the cycle after busy_reg falls.
- Operations:
  - MULT: {HI,LO} = signed(RS) * signed(RT), 64-bit.
  - MULTU: {HI,LO} = unsigned 64-bit product.
  - DIV: LO = signed quotient truncated toward zero; HI = remainder with the sign of the dividend. 0x80000000 / 0xFFFFFFFF gives LO=0x80000000, HI=0.
  - DIVU: unsigned quotient/remainder.
  - Divide by zero (RT==0, DIV or DIVU): full latency elapses, then shadow = current HI/LO, so HI/LO are unchanged.
- MTHI/MTLO: write HI/LO at the next edge, with no busy. Honoured only when state==IDLE and Req==0.
- Any command in BUSY (including MTHI/MTLO) has no effect. The hazard unit guarantees a stall; the block must still ignore it.
- Req=1:
  - Suppresses E_Start and MTHI/MTLO in the same cycle.
  - An operation already in BUSY is architecturally committed and runs to completion unaffected.
- E_HI/E_LO reflect the registers only and never expose the shadow values.
- Reserved opcodes behave as NOP.
- Simultaneous reset and start: reset wins.

Test Plan:
1. MULT: RS=0xFFFFFFFE (-2), RT=3 -> E_Busy high in start cycle + 5 cycles; then HI=0xFFFFFFFF, LO=0xFFFFFFFA.
2. DIV then DIVU:
   - DIV RS=0xFFFFFFF9 (-7), RT=2 -> busy for 1+10 cycles, then LO=0xFFFFFFFD, HI=0xFFFFFFFF.
   - DIVU with the same operands -> LO=0x7FFFFFFC, HI=1.
3. Divide by zero: MTHI 0x1234, MTLO 0x5678, then DIV RS=9, RT=0 -> busy for 11 cycles; HI=0x1234, LO=0x5678 unchanged.
4. Req gating:
   - MULTU 0xFFFFFFFF * 0xFFFFFFFF with Req=1 -> E_Start=0, E_Busy=0, HI/LO unchanged.
   - Same command with Req=0 -> HI=0xFFFFFFFE, LO=0x00000001 after 6 cycles.
   - Req pulsed during BUSY -> completes normally.
5. Commands during BUSY: MTLO 0xAAAA and DIV presented on cycles 2-3 of a MULT 6*7 -> ignored; final HI=0, LO=42, and busy ends on schedule.
6. Reset mid-op: MULT 5*5, then reset low at busy cycle 3 -> next cycle E_Busy=0, HI=LO=0; no late write after reset releases.
